mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL set fixed memory access latency in cycles; legal range 1..7.
REQ-002 Parameter STARVE_MAX, default 4, SHALL set the max consecutive data grants while fetch waits; legal range 1..15.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_req  input  1  fetch read request, held until i_ack.
REQ-007 i_addr  input  64  fetch address.
REQ-008 i_rdata  output  64  fetch read data, valid with i_ack.
REQ-009 i_ack  output  1  one-cycle fetch completion pulse.
REQ-010 i_err  output  1  fetch error, valid with i_ack.
REQ-011 f_stall  output  1  fetch-stage stall.
REQ-012 d_req  input  1  data-stage request, held until d_ack.
REQ-013 d_we  input  1  1 = write, 0 = read.
REQ-014 d_addr  input  64  data address.
REQ-015 d_wdata  input  64  write data.
REQ-016 d_rdata  output  64  read data, valid with d_ack.
REQ-017 d_ack  output  1  one-cycle data completion pulse.
REQ-018 d_err  output  1  data error, valid with d_ack.
REQ-019 m_stall  output  1  memory-stage stall.
REQ-020 mem_en, mem_we  output  1 each  shared-port enable and write strobe.
REQ-021 mem_addr, mem_wdata  output  64 each  shared-port address and write data.
REQ-022 mem_rdata  input  64; mem_err  input  1  shared-port response.

Function
REQ-023 FSM states SHALL be IDLE, I_ACC and D_ACC.
REQ-024 In IDLE, the arbiter SHALL grant d_req over i_req, except when starve_cnt==STARVE_MAX and i_req=1, in which case fetch is granted.
REQ-025 In IDLE, a port whose ack is high in the current cycle SHALL be ineligible, so the same request is never regranted.
REQ-026 On a grant, the arbiter SHALL latch the granted port's addr (plus d_we and d_wdata for data), clear lat_cnt to 0, and enter I_ACC or D_ACC.
REQ-027 Throughout I_ACC/D_ACC, mem_en SHALL be 1 and mem_addr/mem_wdata SHALL be driven from the latched values.
REQ-028 mem_we SHALL be 1 only in D_ACC with latched d_we=1.
REQ-029 lat_cnt (3 bits) SHALL increment each cycle in an access state.
REQ-030 At the edge where lat_cnt==MEM_LAT-1, the arbiter SHALL register mem_rdata and mem_err into the owner's rdata/err, pulse the owner's ack high for the next cycle, and return to IDLE.
REQ-031 Latency from a request sampled in IDLE to ack SHALL be MEM_LAT+1 cycles; minimum spacing between grants is MEM_LAT+1 cycles.
REQ-032 For data writes, d_rdata SHALL be loaded with 0.
REQ-033 Otherwise, rdata/err SHALL hold their value between acks.
REQ-034 i_ack, d_ack, i_err and d_err SHALL be low except in the single ack cycle.
REQ-035 f_stall SHALL equal i_req & ~i_ack, and m_stall SHALL equal d_req & ~d_ack, both combinational.
REQ-036 starve_cnt (4 bits) SHALL increment on each data grant while i_req=1, saturating at STARVE_MAX.
REQ-037 starve_cnt SHALL clear on a fetch grant, and on any IDLE cycle with i_req=0.
REQ-038 Request deassertion before ack SHALL be illegal, and an access in progress SHALL complete regardless.
REQ-039 Input address/data changes during an access SHALL NOT affect mem_addr/mem_wdata.

Reset
REQ-040 While rst_n=0, outputs SHALL asynchronously be: state IDLE; mem_en, mem_we, all acks and errs at 0; mem_addr, mem_wdata, i_rdata, d_rdata at 0; lat_cnt and starve_cnt at 0.
REQ-041 Reset mid-access SHALL abandon the transaction, and no ack for it SHALL ever issue.
REQ-042 The first grant SHALL occur at the first rising edge with rst_n=1.

Verification (MEM_LAT=2, STARVE_MAX=4)
REQ-043 Reset release with i_req=1, i_addr=0x100, mem_rdata=0x30F2 -> mem_en=1 for 2 cycles with mem_addr=0x100; i_ack=1 in cycle 3 with i_rdata=0x30F2; f_stall=1 in cycles 0-2 and 0 in cycle 3.
REQ-044 i_req and d_req (read, 0x200) rise together -> data served first, d_ack in cycle 3; then one dead cycle, fetch granted at cycle 4, i_ack in cycle 7.
REQ-045 d_req held continuously (new address after each ack) with i_req=1 -> exactly 4 data grants, then a fetch grant, then data resumes.
REQ-046 Data write d_addr=0x40, d_wdata=0xDEAD with mem_err=1 at the completion edge -> mem_we=1 only during D_ACC, with mem_wdata=0xDEAD; d_ack=1, d_err=1, d_rdata=0.
REQ-047 rst_n pulled low in the second D_ACC cycle -> mem_en drops immediately; no d_ack follows; m_stall stays 1 until a fresh grant completes after release.
REQ-048 i_addr changed mid-I_ACC -> mem_addr is unchanged, and the returned data corresponds to the latched address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between
// fetch and data requesters, data first, with a fetch starvation guard.
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [63:0] i_addr,
   output logic [63:0] i_rdata,
   output logic        i_ack,
   output logic        i_err,
   output logic        f_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic [63:0] d_rdata,
   output logic        d_ack,
   output logic        d_err,
   output logic        m_stall,
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] I_ACC = 2'd1;
   localparam logic [1:0] D_ACC = 2'd2;

   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);
   localparam logic [3:0] STV_MAX  = 4'(STARVE_MAX);

   logic [1:0] state;
   logic [2:0] lat_cnt;
   logic [3:0] starve_cnt;
   logic       a_we;
   logic       sel_i;
   logic       sel_d;
   logic       gnt_i;
   logic       gnt_d;
   logic       done;

   // Pick a winner on raw requests, then suppress it if it is being acked
   always_comb begin
      sel_i = i_req & ((starve_cnt == STV_MAX) | ~d_req);
      sel_d = d_req & ~sel_i;
      gnt_i = (state == IDLE) & sel_i & ~i_ack;
      gnt_d = (state == IDLE) & sel_d & ~d_ack;
      done  = (state != IDLE) & (lat_cnt == LAT_LAST);
   end

   assign mem_en  = (state != IDLE);
   assign mem_we  = (state == D_ACC) & a_we;
   assign f_stall = i_req & ~i_ack;
   assign m_stall = d_req & ~d_ack;

   // Access FSM and latency counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         lat_cnt <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               lat_cnt <= 3'd0;
               if (gnt_d)
                  state <= D_ACC;
               else if (gnt_i)
                  state <= I_ACC;
            end
            default: begin
               lat_cnt <= lat_cnt + 3'd1;
               if (done)
                  state <= IDLE;
            end
         endcase
      end
   end

   // Capture the granted request so the port ignores later input changes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= 64'd0;
         mem_wdata <= 64'd0;
         a_we      <= 1'b0;
      end else if (gnt_d) begin
         mem_addr  <= d_addr;
         mem_wdata <= d_wdata;
         a_we      <= d_we;
      end else if (gnt_i) begin
         mem_addr  <= i_addr;
         a_we      <= 1'b0;
      end
   end

   // Count data grants that overtook a waiting fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= 4'd0;
      else if (gnt_i)
         starve_cnt <= 4'd0;
      else if (gnt_d && i_req && starve_cnt < STV_MAX)
         starve_cnt <= starve_cnt + 4'd1;
      else if (state == IDLE && !i_req)
         starve_cnt <= 4'd0;
   end

   // Return data to the owner with a single-cycle ack/err pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_ack   <= 1'b0;
         i_err   <= 1'b0;
         i_rdata <= 64'd0;
         d_ack   <= 1'b0;
         d_err   <= 1'b0;
         d_rdata <= 64'd0;
      end else begin
         i_ack <= 1'b0;
         i_err <= 1'b0;
         d_ack <= 1'b0;
         d_err <= 1'b0;
         if (done && state == I_ACC) begin
            i_ack   <= 1'b1;
            i_err   <= mem_err;
            i_rdata <= mem_rdata;
         end else if (done) begin
            d_ack   <= 1'b1;
            d_err   <= mem_err;
            d_rdata <= a_we ? 64'd0 : mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latency,
// starvation guard, writes with error, reset abort and address latching.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [63:0] i_addr;
   logic [63:0] i_rdata;
   logic        i_ack;
   logic        i_err;
   logic        f_stall;
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic [63:0] d_rdata;
   logic        d_ack;
   logic        d_err;
   logic        m_stall;
   logic        mem_en;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_err;

   logic [63:0] rd_const;
   logic        use_model;
   logic        err_drv;

   int total;
   int bad;

   assign mem_rdata = use_model ?
      {mem_addr[31:0], ~mem_addr[31:0]} : rd_const;
   assign mem_err = err_drv;

   mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
      .i_ack(i_ack), .i_err(i_err), .f_stall(f_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .d_err(d_err), .m_stall(m_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] seq;
      int         g;
      logic       prev_en;
      logic       got_ack;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      i_req     = 1'b1;
      i_addr    = 64'h100;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = 64'h0;
      d_wdata   = 64'h0;
      rd_const  = 64'h30F2;
      use_model = 1'b0;
      err_drv   = 1'b0;

      // reset values and first fetch after release
      tick();
      tick();
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_i_ack", i_ack, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_f_stall", f_stall, 1);
      rst_n = 1'b1;
      #1;
      chk("f0_f_stall", f_stall, 1);
      tick();
      chk("f1_mem_en", mem_en, 1);
      chk("f1_mem_addr", mem_addr, 64'h100);
      chk("f1_mem_we", mem_we, 0);
      chk("f1_f_stall", f_stall, 1);
      tick();
      chk("f2_mem_en", mem_en, 1);
      chk("f2_i_ack", i_ack, 0);
      tick();
      chk("f3_mem_en", mem_en, 0);
      chk("f3_i_ack", i_ack, 1);
      chk("f3_i_rdata", i_rdata, 64'h30F2);
      chk("f3_i_err", i_err, 0);
      chk("f3_f_stall", f_stall, 0);
      i_req = 1'b0;
      tick();
      chk("f4_i_ack", i_ack, 0);
      chk("f4_i_rdata_hold", i_rdata, 64'h30F2);

      // simultaneous requests: data first, fetch after the dead cycle
      tick();
      i_req    = 1'b1;
      i_addr   = 64'h300;
      d_req    = 1'b1;
      d_addr   = 64'h200;
      rd_const = 64'h1111;
      tick();
      chk("p1_mem_addr", mem_addr, 64'h200);
      chk("p1_mem_we", mem_we, 0);
      chk("p1_m_stall", m_stall, 1);
      tick();
      tick();
      chk("p3_d_ack", d_ack, 1);
      chk("p3_d_rdata", d_rdata, 64'h1111);
      chk("p3_mem_en", mem_en, 0);
      chk("p3_m_stall", m_stall, 0);
      chk("p3_f_stall", f_stall, 1);
      tick();
      d_req = 1'b0;
      chk("p4_dead_mem_en", mem_en, 0);
      chk("p4_d_ack", d_ack, 0);
      tick();
      rd_const = 64'h2222;
      chk("p5_mem_en", mem_en, 1);
      chk("p5_mem_addr", mem_addr, 64'h300);
      tick();
      chk("p6_i_ack", i_ack, 0);
      tick();
      chk("p7_i_ack", i_ack, 1);
      chk("p7_i_rdata", i_rdata, 64'h2222);
      i_req = 1'b0;

      // continuous data traffic against a waiting fetch
      tick();
      i_req   = 1'b1;
      i_addr  = 64'hF00;
      d_req   = 1'b1;
      d_addr  = 64'h1000;
      seq     = 6'd0;
      g       = 0;
      prev_en = mem_en;
      for (int c = 0; c < 60 && g < 6; c++) begin
         tick();
         if (mem_en && !prev_en) begin
            seq[g] = (mem_addr == 64'hF00);
            g++;
         end
         prev_en = mem_en;
         if (d_ack) d_addr = d_addr + 64'h10;
         if (i_ack) i_req = 1'b0;
      end
      chk("stv_grants", 64'(g), 6);
      chk("stv_seq", 64'(seq), 64'b010000);
      got_ack = 1'b0;
      for (int c = 0; c < 10 && !got_ack; c++) begin
         tick();
         got_ack = d_ack;
      end
      chk("stv_tail_ack", 64'(got_ack), 1);
      d_req = 1'b0;
      i_req = 1'b0;

      // data write with memory error
      tick();
      tick();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 64'h40;
      d_wdata = 64'hDEAD;
      err_drv = 1'b1;
      chk("w0_mem_we", mem_we, 0);
      tick();
      chk("w1_mem_we", mem_we, 1);
      chk("w1_mem_addr", mem_addr, 64'h40);
      chk("w1_mem_wdata", mem_wdata, 64'hDEAD);
      tick();
      chk("w2_mem_we", mem_we, 1);
      tick();
      chk("w3_mem_we", mem_we, 0);
      chk("w3_d_ack", d_ack, 1);
      chk("w3_d_err", d_err, 1);
      chk("w3_d_rdata", d_rdata, 0);
      d_req   = 1'b0;
      d_we    = 1'b0;
      err_drv = 1'b0;
      tick();
      chk("w4_d_err", d_err, 0);
      chk("w4_d_ack", d_ack, 0);

      // reset during the second access cycle
      tick();
      d_req    = 1'b1;
      d_addr   = 64'h80;
      rd_const = 64'h4444;
      tick();
      tick();
      chk("r2_mem_en", mem_en, 1);
      rst_n = 1'b0;
      #1;
      chk("r2_rst_mem_en", mem_en, 0);
      chk("r2_rst_mem_addr", mem_addr, 0);
      chk("r2_rst_m_stall", m_stall, 1);
      tick();
      chk("r3_d_ack", d_ack, 0);
      chk("r3_d_rdata", d_rdata, 0);
      rst_n = 1'b1;
      tick();
      chk("r4_mem_en", mem_en, 1);
      chk("r4_d_ack", d_ack, 0);
      chk("r4_m_stall", m_stall, 1);
      tick();
      chk("r5_d_ack", d_ack, 0);
      chk("r5_m_stall", m_stall, 1);
      tick();
      chk("r6_d_ack", d_ack, 1);
      chk("r6_d_rdata", d_rdata, 64'h4444);
      chk("r6_m_stall", m_stall, 0);
      d_req = 1'b0;

      // fetch address change while the access is running
      tick();
      use_model = 1'b1;
      i_req     = 1'b1;
      i_addr    = 64'h500;
      tick();
      chk("a1_mem_addr", mem_addr, 64'h500);
      i_addr = 64'h999;
      tick();
      chk("a2_mem_addr", mem_addr, 64'h500);
      tick();
      chk("a3_i_ack", i_ack, 1);
      chk("a3_i_rdata", i_rdata, 64'h00000500_FFFFFAFF);
      i_req = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
